binupdncnt_param: RTL and testbench
===================================

Name: binupdncnt_param

Overview:
- Parametrised successor of the fixed 4-bit binary up counter.
- Adds configurable width and modulus, up/down direction, count enable, synchronous parallel load, and wrap-or-saturate mode.
- Adds a combinational terminal-count output for cascading and a registered wrap pulse.
- Used as the generic counter primitive under clock dividers, display scanners and multi-digit counter chains.

Parameters:
WIDTH, 4, counter bit width (>=1)
MAX_VAL, 2**WIDTH-1, highest count value; count range is 0..MAX_VAL (MAX_VAL <= 2**WIDTH-1)
INIT_VAL, 0, value loaded on reset (must be <= MAX_VAL)

Ports:
clk  input  1  global clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  count enable; one step per clk while high
up  input  1  direction: 1 = count up, 0 = count down
load  input  1  synchronous parallel load strobe
din  input  WIDTH  parallel load value
sat  input  1  boundary mode: 1 = saturate at boundary, 0 = wrap modulo MAX_VAL+1
q  output  WIDTH  current count (registered)
tc  output  1  terminal count (combinational), for cascading
wrap  output  1  registered one-cycle pulse; high the cycle after q wrapped

Behaviour:
- Reset: clk and rst are as decided: one clock; reset synchronous, active-high.
  - On a clk edge with rst=1: q <= INIT_VAL, wrap <= 0.
  - rst overrides all other inputs.
  - A reset asserted mid-count takes effect at the next edge only; no asynchronous path.
- Priority per edge: rst > load > en > hold.
- Load (load=1):
  - q <= din if din <= MAX_VAL, else q <= MAX_VAL (clamp).
  - wrap <= 0.
  - en, up and sat are ignored that cycle.
- Count (load=0, en=1), up=1:
  - q < MAX_VAL: q <= q+1.
  - q == MAX_VAL and sat=0: q <= 0, wrap <= 1.
  - q == MAX_VAL and sat=1: q holds, wrap <= 0.
- Count (load=0, en=1), up=0:
  - q > 0: q <= q-1.
  - q == 0 and sat=0: q <= MAX_VAL, wrap <= 1.
  - q == 0 and sat=1: q holds, wrap <= 0.
- Hold (load=0, en=0): q holds, wrap <= 0.
- wrap is a single-cycle pulse. Consecutive wraps (e.g. MAX_VAL=0 with en held) give wrap high on consecutive cycles.
- tc = en & ((up & q==MAX_VAL) | (~up & q==0)):
  - Purely combinational.
  - Asserted regardless of sat.
  - Not gated by load; the downstream stage must not advance while load is active, enforced by the system.
  - Cascade rule: next stage en = tc of this stage.
- Direction change takes effect on the same edge; no pipeline delay. Latency of every operation is 1 clk.
- Arithmetic:
  - Compare and step use WIDTH+1 bits internally so MAX_VAL = 2**WIDTH-1 wraps correctly.
  - q never exceeds MAX_VAL in any state.
- Out-of-range q (only reachable via X at power-up before reset): the next count step treats q > MAX_VAL as a boundary and wraps to 0 (up) or MAX_VAL (down).

Test Plan:
- Defaults (WIDTH=4, MAX_VAL=15), rst=1 for 2 clk, then en=1, up=1, sat=0 for 17 clk -> q: 0,1,…,15,0,1. wrap=1 only in the cycle q=0 appears after 15. tc=1 while q=15.
- MAX_VAL=9 (decade), up=0, sat=0 from q=0 -> q: 9,8,…,0,9. wrap pulses on each 0->9. tc=1 while q=0 and en=1.
- MAX_VAL=9, sat=1, up=1 from q=7, 5 clk -> q: 8,9,9,9,9. wrap stays 0. tc stays 1 at 9. Then up=0 -> q 8.
- load=1, din=12 with MAX_VAL=9 -> q=9. load=1 together with en=1, din=3 -> q=3, no count step. load=1 together with rst=1 -> q=INIT_VAL.
- Two instances cascaded (MAX_VAL=9, stage1 en = tc of stage0), count from 00 for 100 clk -> {q1,q0}: 99 then 00. stage1 wrap pulses once.
- rst asserted while q=6 counting up, deasserted one edge later -> q=INIT_VAL on that edge, resumes counting from INIT_VAL. wrap=0 throughout reset.

Source files
------------

// File: rtl/binupdncnt_param.sv
// binupdncnt_param: generic binary up/down counter primitive.
// Counts 0..MAX_VAL with enable, direction, synchronous parallel load,
// and a choice of wrapping or saturating at the boundary. Provides a
// combinational terminal-count output for cascading stages and a
// registered one-cycle wrap pulse.

module binupdncnt_param #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int unsigned INIT_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // Boundary value held both at counter width and one bit wider, so the
    // comparisons stay correct when MAX_VAL is the full 2**WIDTH-1 range.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);

    // Reset value; an out-of-range INIT_VAL is clamped so q can never
    // leave the legal range, even through reset.
    localparam logic [WIDTH-1:0] INIT_Q  =
        (INIT_VAL > MAX_VAL) ? MAX_Q : WIDTH'(INIT_VAL);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;

    // Decoded views of the current count and load value.
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   din_ext;
    logic             at_max;
    logic             at_zero;
    logic             over_max;
    logic [WIDTH-1:0] din_clamped;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_dec;

    // Boundary detection and step values, all derived from the current count.
    always_comb begin
        q_ext       = {1'b0, q_q};
        din_ext     = {1'b0, din};
        at_max      = (q_ext == MAX_EXT);
        at_zero     = (q_q == '0);
        // Only reachable from an unknown power-up value before reset.
        over_max    = (q_ext > MAX_EXT);
        din_clamped = (din_ext > MAX_EXT) ? MAX_Q : din;
        // Steps are only taken strictly inside the range, so they cannot
        // overflow or underflow at counter width.
        q_inc       = q_q + WIDTH'(1);
        q_dec       = q_q - WIDTH'(1);
    end

    // Next-state selection: rst > load > en > hold.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (rst) begin
            q_d = INIT_Q;
        end else if (load) begin
            q_d = din_clamped;
        end else if (en) begin
            if (up) begin
                if (over_max) begin
                    // Recover an illegal count regardless of sat mode.
                    q_d = '0;
                end else if (at_max) begin
                    if (!sat) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q_inc;
                end
            end else begin
                if (over_max) begin
                    q_d = MAX_Q;
                end else if (at_zero) begin
                    if (!sat) begin
                        q_d    = MAX_Q;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q_dec;
                end
            end
        end
    end

    // State register; reset is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        q_q    <= q_d;
        wrap_q <= wrap_d;
    end

    // Terminal count for cascading: the next stage advances exactly when
    // this one sits on its boundary in the current direction. Not gated by
    // sat or load.
    always_comb begin
        tc = en & ((up & at_max) | (~up & at_zero));
    end

    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_binupdncnt_param.sv
// Testbench for binupdncnt_param: directed test-plan sequences followed by
// randomized stimulus, all checked against a modulus-arithmetic model.
// Also exercises a two-stage decade cascade.

module tb_binupdncnt_param;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for instance a (defaults) and b (decade, INIT 3)
  logic       rst, en, up, load, sat;
  logic [3:0] din;
  logic [3:0] q_a, q_b;
  logic       tc_a, tc_b, wrap_a, wrap_b;

  binupdncnt_param u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .sat(sat), .q(q_a), .tc(tc_a), .wrap(wrap_a)
  );

  binupdncnt_param #(.WIDTH(4), .MAX_VAL(9), .INIT_VAL(3)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .sat(sat), .q(q_b), .tc(tc_b), .wrap(wrap_b)
  );

  // Two-stage decade cascade
  logic       rst_c, en_c0;
  logic [3:0] q_c0, q_c1;
  logic       tc_c0, tc_c1, wrap_c0, wrap_c1;

  binupdncnt_param #(.WIDTH(4), .MAX_VAL(9)) u_c0 (
    .clk(clk), .rst(rst_c), .en(en_c0), .up(1'b1), .load(1'b0), .din(4'd0),
    .sat(1'b0), .q(q_c0), .tc(tc_c0), .wrap(wrap_c0)
  );

  binupdncnt_param #(.WIDTH(4), .MAX_VAL(9)) u_c1 (
    .clk(clk), .rst(rst_c), .en(tc_c0), .up(1'b1), .load(1'b0), .din(4'd0),
    .sat(1'b0), .q(q_c1), .tc(tc_c1), .wrap(wrap_c1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Count range is the ring 0..m; a step is +1 or -1 modulo (m+1).
  int mq_a, mq_b;
  int mw_a, mw_b;

  function automatic void model_next(input int q, input int m, input int init,
                                     input logic r, input logic l, input int d,
                                     input logic e, input logic u, input logic s,
                                     output int nq, output int nw);
    nq = q;
    nw = 0;
    if (r) begin
      nq = init;
    end else if (l) begin
      nq = (d > m) ? m : d;
    end else if (e) begin
      if (u) begin
        if (!(s && q == m)) begin
          nq = (q + 1) % (m + 1);
          nw = (q == m) ? 1 : 0;
        end
      end else begin
        if (!(s && q == 0)) begin
          nq = (q + m) % (m + 1);
          nw = (q == 0) ? 1 : 0;
        end
      end
    end
  endfunction

  function automatic int model_tc(input int q, input int m, input logic e, input logic u);
    return (e && ((u && q == m) || (!u && q == 0))) ? 1 : 0;
  endfunction

  // ---------------- driver ----------------
  // One clock: apply inputs, check tc, clock, advance model, check q/wrap.
  task automatic cycle(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] d, input logic s);
    int nq, nw;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; din = d; sat = s;
    #1;
    check("tc_a", {31'd0, tc_a}, model_tc(mq_a, 15, e, u));
    check("tc_b", {31'd0, tc_b}, model_tc(mq_b, 9, e, u));
    @(posedge clk);
    model_next(mq_a, 15, 0, r, l, int'(d), e, u, s, nq, nw);
    mq_a = nq; mw_a = nw;
    model_next(mq_b, 9, 3, r, l, int'(d), e, u, s, nq, nw);
    mq_b = nq; mw_b = nw;
    #1;
    check("q_a", {28'd0, q_a}, mq_a);
    check("wrap_a", {31'd0, wrap_a}, mw_a);
    check("q_b", {28'd0, q_b}, mq_b);
    check("wrap_b", {31'd0, wrap_b}, mw_b);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wrap1_cnt;
    int exp_val;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0; sat = 1'b0;
    rst_c = 1'b1; en_c0 = 1'b0;
    mq_a = 0; mq_b = 3; mw_a = 0; mw_b = 0;

    // Reset for two clocks
    cycle(1, 0, 1, 0, 4'd0, 0);
    cycle(1, 1, 1, 0, 4'd0, 0);
    check("rst_q_a", {28'd0, q_a}, 0);
    check("rst_q_b", {28'd0, q_b}, 3);

    // Default counter up 17 clocks: 1..15,0,1 with a wrap pulse after 15
    for (int i = 1; i <= 17; i++) exp_q.push_back(4'(i % 16));
    for (int i = 1; i <= 17; i++) begin
      logic [3:0] e;
      cycle(0, 1, 1, 0, 4'd0, 0);
      e = exp_q.pop_front();
      check("seq_q_a", {28'd0, q_a}, {28'd0, e});
      check("seq_wrap_a", {31'd0, wrap_a}, (i == 16) ? 1 : 0);
    end

    // Decade counting down from 0 with wrap
    cycle(0, 0, 1, 1, 4'd0, 0);
    for (int i = 0; i < 11; i++) cycle(0, 1, 0, 0, 4'd0, 0);
    check("dn_q_b", {28'd0, q_b}, 9);

    // Saturate up from 7, then step down
    cycle(0, 0, 1, 1, 4'd7, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 4'd0, 1);
    check("sat_q_b", {28'd0, q_b}, 9);
    check("sat_wrap_b", {31'd0, wrap_b}, 0);
    cycle(0, 1, 0, 0, 4'd0, 1);
    check("sat_dn_q_b", {28'd0, q_b}, 8);

    // Load clamp, load over count, reset over load
    cycle(0, 0, 1, 1, 4'd12, 0);
    check("clamp_q_b", {28'd0, q_b}, 9);
    check("noclamp_q_a", {28'd0, q_a}, 12);
    cycle(0, 1, 1, 1, 4'd3, 0);
    check("ld_en_q_b", {28'd0, q_b}, 3);
    cycle(1, 1, 1, 1, 4'd7, 0);
    check("ld_rst_q_a", {28'd0, q_a}, 0);
    check("ld_rst_q_b", {28'd0, q_b}, 3);

    // Reset asserted mid-count, then resume from INIT_VAL
    cycle(0, 0, 1, 1, 4'd5, 0);
    cycle(0, 1, 1, 0, 4'd0, 0);
    check("mid_q_a", {28'd0, q_a}, 6);
    cycle(1, 1, 1, 0, 4'd0, 0);
    check("mid_rst_q_a", {28'd0, q_a}, 0);
    cycle(0, 1, 1, 0, 4'd0, 0);
    check("mid_resume_q_a", {28'd0, q_a}, 1);
    check("mid_resume_q_b", {28'd0, q_b}, 4);

    // Randomized stimulus
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
    end

    // Cascade: two decades count 00..99 then 00
    @(negedge clk);
    rst_c = 1'b1;
    @(posedge clk); #1;
    check("casc_rst", {24'd0, q_c1, q_c0}, 0);
    @(negedge clk);
    rst_c = 1'b0;
    en_c0 = 1'b1;
    wrap1_cnt = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      exp_val = n % 100;
      check("casc_val", 32'(q_c1) * 10 + 32'(q_c0), exp_val);
      if (wrap_c1) wrap1_cnt++;
    end
    @(negedge clk);
    en_c0 = 1'b0;
    check("casc_wrap1_cnt", wrap1_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
